// File: rtl/press_pkg.sv
// press_pkg: FSM state encoding and default press timing shared by press_gen and the press detector.
package press_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, WAIT_ACK, GAP, FIN} state_e;
  localparam int DEF_HOLD_CYCLES    = 6;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int TMR_W              = 8;
endpackage

// File: rtl/press_timer.sv
// press_timer: loadable down-counter that stops at zero; expired flags the zero count.
module press_timer
  import press_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= load_i ? load_val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/press_gen.sv
// press_gen: burst press pulse generator waiting for a detector ack after every press.
// Optional PRESS_TIMEOUT_EN bounds WAIT_ACK and reports a sticky err flag.
module press_gen
  import press_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  input  logic             ack_in,
  output logic             press_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] presses_sent,
  output logic             err
);
  localparam int GAP_M1 = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  localparam int TO_M1  = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;
  state_e state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, sent_q, sent_d;
  logic ack_seen_q, ack_seen_d;
  logic ready_q, press_q, busy_q, done_q;
  logic accept, ack, timeout, tmr_load, tmr_exp;
  logic [TMR_W-1:0] tmr_val;
  assign accept = cmd_valid & ready_q;
  assign ack    = ack_in | ack_seen_q;
`ifdef PRESS_TIMEOUT_EN
  logic err_q, err_d;
  assign timeout = tmr_exp & ~ack;
  assign err_d   = accept ? 1'b0 : (state_q == WAIT_ACK && timeout) ? 1'b1 : err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sent_d     = sent_q;
    ack_seen_d = ack_seen_q;
    case (state_q)
      IDLE: if (accept) begin
        rem_d   = cmd_count;
        sent_d  = '0;
        state_d = (cmd_count != '0) ? HOLD : FIN;
      end
      HOLD: begin
        ack_seen_d = ack_seen_q | ack_in;
        state_d    = tmr_exp ? WAIT_ACK : HOLD;
      end
      WAIT_ACK: if (ack) begin
        sent_d  = &sent_q ? sent_q : sent_q + 1'b1;
        rem_d   = (rem_q != '0) ? rem_q - 1'b1 : rem_q;
        state_d = (GAP_CYCLES != 0) ? GAP : (rem_q > CNT_W'(1)) ? HOLD : FIN;
      end else if (timeout) state_d = FIN;
      GAP:      if (tmr_exp) state_d = (rem_q != '0) ? HOLD : FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_d == HOLD && state_q != HOLD) ack_seen_d = 1'b0;
  end
  // one timer reloaded on every state change covers hold, gap and ack timeout
  assign tmr_load = state_d != state_q;
  assign tmr_val  = state_d == HOLD     ? TMR_W'(HOLD_CYCLES - 1) :
                    state_d == GAP      ? TMR_W'(GAP_M1) :
                    state_d == WAIT_ACK ? TMR_W'(TO_M1) : '0;
  press_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      sent_q     <= '0;
      ack_seen_q <= 1'b0;
      ready_q    <= 1'b0;
      press_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sent_q     <= sent_d;
      ack_seen_q <= ack_seen_d;
      ready_q    <= state_d == IDLE;
      press_q    <= state_d == HOLD;
      busy_q     <= state_d inside {HOLD, WAIT_ACK, GAP};
      done_q     <= state_d == FIN;
    end
  assign cmd_ready    = ready_q;
  assign press_out    = press_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign presses_sent = sent_q;
endmodule

// File: tb/tb_press_gen.sv
// tb_press_gen: randomized bursts for press_gen checked against timing rules computed in the bench.
module tb_press_gen;
  localparam int HOLD = 6;
  localparam int GAP  = 2;
  localparam int TO   = 16;
  logic       clk = 0, reset = 0, cmd_valid = 0, ack_in = 0;
  logic [7:0] cmd_count = '0;
  logic       cmd_ready, press_out, busy, done, err;
  logic [7:0] presses_sent;
  int checks = 0, failures = 0;
  press_gen dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_count    (cmd_count),
    .cmd_ready    (cmd_ready),
    .ack_in       (ack_in),
    .press_out    (press_out),
    .busy         (busy),
    .done         (done),
    .presses_sent (presses_sent),
    .err          (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", int'(cmd_ready), 1);
  endtask
  task automatic issue(input int n);
    wait_ready();
    cmd_valid = 1;
    cmd_count = 8'(n);
    @(negedge clk);
    cmd_valid = 0;
    chk("ready_drop", int'(cmd_ready), 0);
    chk("err_clr", int'(err), 0);
    chk("sent_clr", int'(presses_sent), 0);
  endtask
  // early=1 acks somewhere in HOLD; otherwise ack after a random WAIT_ACK delay
  task automatic run_burst(input int n, input bit early);
    int hi, lo, d, at;
    issue(n);
    if (n == 0) begin
      chk("z_done", int'(done), 1);
      chk("z_press", int'(press_out), 0);
      chk("z_busy", int'(busy), 0);
    end
    for (int i = 0; i < n; i++) begin
      at = $urandom_range(1, HOLD);
      d  = early ? 0 : $urandom_range(0, 4);
      hi = 0;
      while (press_out && hi < 20) begin
        hi++;
        chk("busy_hold", int'(busy), 1);
        chk("ready_hold", int'(cmd_ready), 0);
        ack_in    = early && (hi == at);
        cmd_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      ack_in    = 0;
      cmd_valid = 0;
      chk("hold_len", hi, HOLD);
      lo = 0;
      repeat (d) begin
        chk("wait_sent", int'(presses_sent), i);
        @(negedge clk);
        lo++;
      end
      ack_in = !early;
      @(negedge clk);
      lo++;
      ack_in = 0;
      chk("sent_inc", int'(presses_sent), i + 1);
      while (!press_out && !done && lo < 50) begin
        ack_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        lo++;
      end
      ack_in = 0;
      chk("low_len", lo, d + 1 + GAP);
    end
    if (n > 0) begin
      chk("done", int'(done), 1);
      chk("busy_fin", int'(busy), 0);
      chk("press_fin", int'(press_out), 0);
    end
    chk("sent_fin", int'(presses_sent), n);
    @(negedge clk);
    chk("done_1cyc", int'(done), 0);
    chk("ready_back", int'(cmd_ready), 1);
  endtask
  initial begin
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_press", int'(press_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sent", int'(presses_sent), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    reset = 0;
    @(negedge clk);
    chk("ready_rise", int'(cmd_ready), 1);
    run_burst(1, 0);
    run_burst(3, 0);
    run_burst(0, 0);
    run_burst(2, 1);
    for (int k = 0; k < 12; k++) run_burst(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
`ifdef PRESS_TIMEOUT_EN
    begin
      int lo = 0;
      issue(2);
      repeat (HOLD) @(negedge clk);
      while (!done && lo < 40) begin
        @(negedge clk);
        lo++;
      end
      chk("to_len", lo, TO);
      chk("to_err", int'(err), 1);
      chk("to_sent", int'(presses_sent), 0);
      chk("to_busy", int'(busy), 0);
      @(negedge clk);
      chk("to_sticky", int'(err), 1);
      chk("to_ready", int'(cmd_ready), 1);
      run_burst(1, 1);
    end
`else
    issue(1);
    repeat (HOLD) @(negedge clk);
    repeat (40) @(negedge clk);
    chk("nto_busy", int'(busy), 1);
    chk("nto_done", int'(done), 0);
    chk("nto_press", int'(press_out), 0);
    chk("nto_err", int'(err), 0);
    ack_in = 1;
    @(negedge clk);
    ack_in = 0;
    chk("nto_sent", int'(presses_sent), 1);
    repeat (GAP) @(negedge clk);
    chk("nto_fin", int'(done), 1);
    @(negedge clk);
`endif
    issue(2);
    repeat (2) @(negedge clk);
    chk("rst_pre", int'(press_out), 1);
    #2 reset = 1;
    #1;
    chk("rst_async_press", int'(press_out), 0);
    chk("rst_async_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_rel_ready", int'(cmd_ready), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_done", int'(done), 0);
    end
    chk("rst_ready_back", int'(cmd_ready), 1);
    chk("rst_sent0", int'(presses_sent), 0);
    run_burst(2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
